// File: rtl/axil_program_loader_pkg.sv
// Shared types for the AXI4-Lite program loader: FSM states and AXI response codes.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
      RESP,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_program_loader_packer.sv
// Packs a byte stream little-endian into BYTES-wide words with valid/ready on both sides.
module byte_word_packer #(
   parameter int BYTES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [8*BYTES-1:0] out_data,
   input  logic               out_ready
);

   localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [CNT_W-1:0] count;
   logic             full;

   assign in_ready  = !full;
   assign out_valid = full;

   // A completed word blocks further bytes until the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count    <= '0;
         full     <= 1'b0;
         out_data <= '0;
      end else if (full) begin
         if (out_ready) begin
            full  <= 1'b0;
            count <= '0;
         end
      end else if (in_valid) begin
         for (int k = 0; k < BYTES; k++) begin
            if (count == CNT_W'(k)) begin
               out_data[8*k +: 8] <= in_data;
            end
         end
         if (count == CNT_W'(BYTES - 1)) begin
            full  <= 1'b1;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/axil_program_loader.sv
// Streams a program image into instruction BRAM over AXI4-Lite writes, then raises cpu_start.
module axil_program_loader
   import loader_pkg::*;
#(
   parameter int                 ADDR_W       = 20,
   parameter int                 DATA_W       = 32,
   parameter int unsigned        BASE_ADDR    = 0,
   parameter int                 NUM_WORDS    = 88,
   parameter int                 APPEND_TERM  = 1,
   parameter logic [DATA_W-1:0]  TERM_WORD    = DATA_W'(32'hFFFF_FFFF),
   parameter int                 RESP_TIMEOUT = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load,
   input  logic                           in_valid,
   input  logic [7:0]                     in_data,
   output logic                           in_ready,
   output logic                           awvalid,
   output logic [ADDR_W-1:0]              awaddr,
   input  logic                           awready,
   output logic                           wvalid,
   output logic [DATA_W-1:0]              wdata,
   output logic [DATA_W/8-1:0]            wstrb,
   input  logic                           wready,
   input  logic                           bvalid,
   output logic                           bready,
   input  logic [1:0]                     bresp,
   output logic                           busy,
   output logic                           done,
   output logic                           error,
   output logic                           cpu_start,
   output logic [$clog2(NUM_WORDS+2)-1:0] words_done
);

   localparam int BYTES = DATA_W / 8;
   localparam int IDX_W = $clog2(NUM_WORDS + 2);
   localparam int TO_W  = $clog2(RESP_TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   state_t            state, next_state;
   logic [IDX_W-1:0]  index, next_index;
   logic [TO_W-1:0]   timeout_count;
   logic              term_phase;
   logic              start_image, start_term, restart, resp_ok;
   logic              pk_in_valid, pk_in_ready, pk_valid, pk_ready;
   logic [DATA_W-1:0] pk_data;

   // Address wraps silently at the top of the AXI address space.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx);
      return BASE + ADDR_W'(idx) * ADDR_W'(BYTES);
   endfunction

   byte_word_packer #(.BYTES(BYTES)) packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (restart),
      .in_valid  (pk_in_valid),
      .in_data   (in_data),
      .in_ready  (pk_in_ready),
      .out_valid (pk_valid),
      .out_data  (pk_data),
      .out_ready (pk_ready)
   );

   assign pk_in_valid = in_valid && (state == COLLECT);
   assign in_ready    = pk_in_ready && (state == COLLECT);
   assign bready      = (state == RESP);
   assign busy        = (state == COLLECT) || (state == WRITE) || (state == RESP);
   assign done        = (state == DONE);
   assign cpu_start   = done;
   assign error       = (state == ERR);
   assign wstrb       = '1;

   always_comb begin
      next_state  = state;
      next_index  = index;
      start_image = 1'b0;
      start_term  = 1'b0;
      restart     = 1'b0;
      resp_ok     = 1'b0;
      pk_ready    = 1'b0;
      case (state)
         IDLE, DONE, ERR: begin
            if (load) begin
               restart    = 1'b1;
               next_index = '0;
               if (NUM_WORDS > 0) begin
                  next_state = COLLECT;
               end else if (APPEND_TERM != 0) begin
                  next_state = WRITE;
                  start_term = 1'b1;
               end else begin
                  next_state = DONE;
               end
            end
         end
         COLLECT: begin
            if (pk_valid) begin
               pk_ready    = 1'b1;
               start_image = 1'b1;
               next_state  = WRITE;
            end
         end
         WRITE: begin
            if ((!awvalid || awready) && (!wvalid || wready)) begin
               next_state = RESP;
            end
         end
         RESP: begin
            if (bvalid) begin
               if (bresp == AXI_RESP_OKAY) begin
                  resp_ok    = 1'b1;
                  next_index = index + 1'b1;
                  if (term_phase) begin
                     next_state = DONE;
                  end else if (next_index < IDX_W'(NUM_WORDS)) begin
                     next_state = COLLECT;
                  end else if (APPEND_TERM != 0) begin
                     next_state = WRITE;
                     start_term = 1'b1;
                  end else begin
                     next_state = DONE;
                  end
               end else begin
                  next_state = ERR;
               end
            end else if (timeout_count == TO_W'(RESP_TIMEOUT - 1)) begin
               next_state = ERR;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // AW and W valids launch together and retire independently on their own handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         index         <= '0;
         words_done    <= '0;
         timeout_count <= '0;
         term_phase    <= 1'b0;
         awvalid       <= 1'b0;
         wvalid        <= 1'b0;
         awaddr        <= '0;
         wdata         <= '0;
      end else begin
         state <= next_state;
         index <= next_index;
         if (restart) begin
            words_done <= '0;
            term_phase <= 1'b0;
         end
         if (resp_ok) begin
            words_done <= words_done + 1'b1;
         end
         if (state != RESP) begin
            timeout_count <= '0;
         end else if (!bvalid) begin
            timeout_count <= timeout_count + 1'b1;
         end
         if (start_image || start_term) begin
            awvalid    <= 1'b1;
            wvalid     <= 1'b1;
            awaddr     <= word_addr(next_index);
            wdata      <= start_term ? TERM_WORD : pk_data;
            term_phase <= start_term;
         end else begin
            if (awready) begin
               awvalid <= 1'b0;
            end
            if (wready) begin
               wvalid <= 1'b0;
            end
         end
      end
   end

endmodule
